// File: rtl/framebuffer_reader.sv
// VGA scan-out of a 256x256 8bpp image from data memory, black outside the window; FB_BORDER_EN paints the window perimeter white.
// Latency: memory strobe 1 clk, video outputs 2 clk behind the h/v counters; no backpressure, memory answers in one cycle.
module framebuffer_reader #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_read_enable,
    output logic [13:0] mem_address,
    input  logic [31:0] mem_data,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [7:0]  pixel,
    output logic        frame_done
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // 10-bit counters cover totals up to 1024 in either direction
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0]  h;
    logic [9:0]  v;
    logic        in_win;
    logic        word_start;
    logic        visible;

    logic        s1_win;
    logic [1:0]  s1_sel;
    logic        s1_de;
    logic        s1_hs;
    logic        s1_vs;
    logic        s1_fd;

    logic        s2_win;
    logic [1:0]  s2_sel;
    logic [31:0] word_q;
    logic [31:0] word_cur;

`ifdef FB_BORDER_EN
    logic        perim;
    logic        s1_border;
    logic        s2_border;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h <= 10'd0;
            v <= 10'd0;
        end else if (h == H_LAST) begin
            h <= 10'd0;
            v <= (v == V_LAST) ? 10'd0 : v + 10'd1;
        end else begin
            h <= h + 10'd1;
        end
    end

    assign in_win     = (h[9:8] == 2'b00) && (v[9:8] == 2'b00);
    assign word_start = in_win && (h[1:0] == 2'b00);
    assign visible    = (h < H_VIS) && (v < V_VIS);

`ifdef FB_BORDER_EN
    assign perim = (h[7:0] == 8'h00) || (h[7:0] == 8'hFF) ||
                   (v[7:0] == 8'h00) || (v[7:0] == 8'hFF);
`endif

    // Stage 1: memory request plus the per-pixel attributes that travel with it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_read_enable <= 1'b0;
            mem_address     <= 14'd0;
            s1_win          <= 1'b0;
            s1_sel          <= 2'd0;
            s1_de           <= 1'b0;
            s1_hs           <= 1'b1;
            s1_vs           <= 1'b1;
            s1_fd           <= 1'b0;
        end else begin
            mem_read_enable <= word_start;
            if (word_start) begin
                mem_address <= {v[7:0], h[7:2]};
            end
            s1_win <= in_win && visible;
            s1_sel <= h[1:0];
            s1_de  <= visible;
            s1_hs  <= !((h >= HS_BEG) && (h < HS_END));
            s1_vs  <= !((v >= VS_BEG) && (v < VS_END));
            s1_fd  <= (h == 10'd0) && (v == V_VIS);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            de         <= 1'b0;
            hsync      <= 1'b1;
            vsync      <= 1'b1;
            frame_done <= 1'b0;
            s2_win     <= 1'b0;
            s2_sel     <= 2'd0;
        end else begin
            de         <= s1_de;
            hsync      <= s1_hs;
            vsync      <= s1_vs;
            frame_done <= s1_fd;
            s2_win     <= s1_win;
            s2_sel     <= s1_sel;
        end
    end

`ifdef FB_BORDER_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_border <= 1'b0;
            s2_border <= 1'b0;
        end else begin
            s1_border <= perim;
            s2_border <= s1_border;
        end
    end
`endif

    // Word is held for bytes 1..3; byte 0 comes straight off the memory's output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q <= 32'd0;
        end else if (s2_win && (s2_sel == 2'd0)) begin
            word_q <= mem_data;
        end
    end

    always_comb begin
        word_cur = (s2_sel == 2'd0) ? mem_data : word_q;
        pixel    = 8'h00;
        if (s2_win) begin
            case (s2_sel)
                2'd0:    pixel = word_cur[7:0];
                2'd1:    pixel = word_cur[15:8];
                2'd2:    pixel = word_cur[23:16];
                default: pixel = word_cur[31:24];
            endcase
`ifdef FB_BORDER_EN
            if (s2_border) begin
                pixel = 8'hFF;
            end
`endif
        end
    end

endmodule

// File: tb/tb_framebuffer_reader.sv
// Bench for framebuffer_reader: short vertical timing so whole frames fit, spot-check table plus per-cycle scoreboard.
module tb_framebuffer_reader;

    localparam int H_ACT = 640;
    localparam int H_FP  = 16;
    localparam int H_SY  = 96;
    localparam int H_BP  = 48;
    localparam int V_ACT = 16;
    localparam int V_FP  = 2;
    localparam int V_SY  = 2;
    localparam int V_BP  = 2;
    localparam int H_TOT = 800;
    localparam int V_TOT = 22;
    localparam int FRAME = H_TOT * V_TOT;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_read_enable;
    logic [13:0] mem_address;
    logic [31:0] mem_data = 32'd0;
    logic        hsync;
    logic        vsync;
    logic        de;
    logic [7:0]  pixel;
    logic        frame_done;

    logic [31:0] mem [0:16383];

    framebuffer_reader #(
        .H_ACTIVE(H_ACT), .H_FP(H_FP), .H_SYNC(H_SY), .H_BP(H_BP),
        .V_ACTIVE(V_ACT), .V_FP(V_FP), .V_SYNC(V_SY), .V_BP(V_BP)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_read_enable(mem_read_enable),
        .mem_address    (mem_address),
        .mem_data       (mem_data),
        .hsync          (hsync),
        .vsync          (vsync),
        .de             (de),
        .pixel          (pixel),
        .frame_done     (frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_read_enable) mem_data <= mem[mem_address];
    end

    typedef struct { logic de; logic hs; logic vs; logic fd; logic [7:0] pix; } out_t;
    typedef struct { logic rd; logic [13:0] addr; } memo_t;
    typedef struct {
        int h; int v; logic rd; logic [13:0] addr;
        logic de; logic hs; logic vs; logic fd; logic [7:0] pix;
    } vec_t;

    out_t        out_q[$];
    memo_t       mem_q[$];
    vec_t        tbl[$];
    out_t        sb_o;
    memo_t       sb_m;
    int          mh = 0;
    int          mv = 0;
    int          cyc = 0;
    logic [13:0] last_addr = 14'd0;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic out_t model_out(input int x, input int y);
        out_t o;
        logic [31:0] w;
        o.de  = (x < H_ACT) && (y < V_ACT);
        o.hs  = !((x >= H_ACT + H_FP) && (x < H_ACT + H_FP + H_SY));
        o.vs  = !((y >= V_ACT + V_FP) && (y < V_ACT + V_FP + V_SY));
        o.fd  = (x == 0) && (y == V_ACT);
        o.pix = 8'h00;
        if (o.de && x < 256 && y < 256) begin
            w = mem[y * 64 + x / 4];
            o.pix = w[8 * (x % 4) +: 8];
`ifdef FB_BORDER_EN
            if (x == 0 || x == 255 || y == 0 || y == 255) o.pix = 8'hFF;
`endif
        end
        return o;
    endfunction

    // Reference scan position advances with the DUT; expectations queued per counter cycle
    always @(posedge clk) begin
        if (rst) begin
            mh = 0; mv = 0; cyc = 0; last_addr = 14'd0;
            out_q.delete();
            mem_q.delete();
        end else begin
            sb_m.rd = (mh < 256) && (mv < 256) && (mh % 4 == 0);
            if (sb_m.rd) last_addr = 14'(mv * 64 + mh / 4);
            sb_m.addr = last_addr;
            mem_q.push_back(sb_m);
            out_q.push_back(model_out(mh, mv));
            mh++;
            if (mh == H_TOT) begin
                mh = 0;
                mv++;
                if (mv == V_TOT) mv = 0;
            end
            cyc++;
        end
    end

    always @(negedge clk) begin
        if (!rst && errors < 20) begin
            if (mem_q.size() > 0) begin
                sb_m = mem_q.pop_front();
                check($sformatf("sb_mem cyc%0d", cyc), 32'({mem_read_enable, mem_address}),
                      32'({sb_m.rd, sb_m.addr}));
            end
            if (out_q.size() >= 2) begin
                sb_o = out_q.pop_front();
                check($sformatf("sb_out cyc%0d", cyc), 32'({de, hsync, vsync, frame_done, pixel}),
                      32'({sb_o.de, sb_o.hs, sb_o.vs, sb_o.fd, sb_o.pix}));
            end
        end
    end

    task automatic wait_cyc(input int target);
        int g;
        g = 0;
        while (cyc < target && g < 100000) begin
            @(negedge clk);
            g++;
        end
        if (cyc != target) begin
            checks++;
            errors++;
            $display("FAIL wait_cyc: reached cycle %0d, wanted %0d", cyc, target);
        end
    endtask

    task automatic add(input int h, input int v, input logic rd, input logic [13:0] addr,
                       input logic de_e, input logic hs_e, input logic vs_e, input logic fd_e,
                       input logic [7:0] pix);
        vec_t e;
        e.h = h; e.v = v; e.rd = rd; e.addr = addr;
        e.de = de_e; e.hs = hs_e; e.vs = vs_e; e.fd = fd_e; e.pix = pix;
        tbl.push_back(e);
    endtask

    initial begin
        int p;
        int g;
        int c1;
        int c2;
        logic [26:0] rst_exp;
        logic [7:0]  first_pix;

`ifdef FB_BORDER_EN
        for (int i = 0; i < 16384; i++) mem[i] = 32'd0;
        first_pix = 8'hFF;
        add(0,   0, 1, 14'd0,   1, 1, 1, 0, 8'hFF);
        add(10,  0, 0, 14'd2,   1, 1, 1, 0, 8'hFF);
        add(1,   1, 0, 14'd64,  1, 1, 1, 0, 8'h00);
        add(0,   2, 1, 14'd128, 1, 1, 1, 0, 8'hFF);
        add(254, 3, 0, 14'd255, 1, 1, 1, 0, 8'h00);
        add(255, 3, 0, 14'd255, 1, 1, 1, 0, 8'hFF);
`else
        for (int i = 0; i < 16384; i++) mem[i] = 32'(i) * 32'h9E3779B1;
        mem[0]   = 32'h44332211;
        mem[1]   = 32'h88776655;
        mem[322] = 32'hDDCCBBAA;
        first_pix = 8'h11;
        add(0,  0, 1, 14'd0,   1, 1, 1, 0, 8'h11);
        add(1,  0, 0, 14'd0,   1, 1, 1, 0, 8'h22);
        add(2,  0, 0, 14'd0,   1, 1, 1, 0, 8'h33);
        add(3,  0, 0, 14'd0,   1, 1, 1, 0, 8'h44);
        add(4,  0, 1, 14'd1,   1, 1, 1, 0, 8'h55);
        add(7,  0, 0, 14'd1,   1, 1, 1, 0, 8'h88);
        add(8,  5, 1, 14'd322, 1, 1, 1, 0, 8'hAA);
        add(9,  5, 0, 14'd322, 1, 1, 1, 0, 8'hBB);
        add(10, 5, 0, 14'd322, 1, 1, 1, 0, 8'hCC);
        add(11, 5, 0, 14'd322, 1, 1, 1, 0, 8'hDD);
`endif
        add(300, 5,  0, 14'd383,  1, 1, 1, 0, 8'h00);
        add(639, 5,  0, 14'd383,  1, 1, 1, 0, 8'h00);
        add(640, 5,  0, 14'd383,  0, 1, 1, 0, 8'h00);
        add(655, 5,  0, 14'd383,  0, 1, 1, 0, 8'h00);
        add(656, 5,  0, 14'd383,  0, 0, 1, 0, 8'h00);
        add(751, 5,  0, 14'd383,  0, 0, 1, 0, 8'h00);
        add(752, 5,  0, 14'd383,  0, 1, 1, 0, 8'h00);
        add(799, 15, 0, 14'd1023, 0, 1, 1, 0, 8'h00);
        add(0,   16, 1, 14'd1024, 0, 1, 1, 1, 8'h00);
        add(1,   16, 0, 14'd1024, 0, 1, 1, 0, 8'h00);
        add(799, 17, 0, 14'd1151, 0, 1, 1, 0, 8'h00);
        add(0,   18, 1, 14'd1152, 0, 1, 0, 0, 8'h00);
        add(799, 19, 0, 14'd1279, 0, 1, 0, 0, 8'h00);
        add(0,   20, 1, 14'd1280, 0, 1, 1, 0, 8'h00);

        rst_exp = {1'b0, 14'd0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};

        repeat (2) @(negedge clk);
        check("reset_state", 32'({mem_read_enable, mem_address, hsync, vsync, de, pixel, frame_done}),
              32'(rst_exp));
        rst = 1'b0;

        foreach (tbl[i]) begin
            p = tbl[i].v * H_TOT + tbl[i].h;
            wait_cyc(p + 1);
            check($sformatf("vec%0d mem h%0d v%0d", i, tbl[i].h, tbl[i].v),
                  32'({mem_read_enable, mem_address}), 32'({tbl[i].rd, tbl[i].addr}));
            wait_cyc(p + 2);
            check($sformatf("vec%0d out h%0d v%0d", i, tbl[i].h, tbl[i].v),
                  32'({de, hsync, vsync, frame_done, pixel}),
                  32'({tbl[i].de, tbl[i].hs, tbl[i].vs, tbl[i].fd, tbl[i].pix}));
        end

        // frame_done spacing across a full frame
        g = 0;
        while (frame_done !== 1'b1 && g < 40000) begin @(negedge clk); g++; end
        check("fd_seen_a", 32'(frame_done), 32'd1);
        c1 = cyc;
        check("fd_second_frame_cycle", 32'(c1), 32'(V_ACT * H_TOT + 2 + FRAME));
        @(negedge clk);
        g = 0;
        while (frame_done !== 1'b1 && g < 40000) begin @(negedge clk); g++; end
        check("fd_seen_b", 32'(frame_done), 32'd1);
        c2 = cyc;
        check("fd_period", 32'(c2 - c1), 32'(FRAME));

        // asynchronous reset in the middle of a visible line
        wait_cyc(c2 + 5 * H_TOT + 100);
        #2 rst = 1'b1;
        #1 check("rst_async", 32'({mem_read_enable, mem_address, hsync, vsync, de, pixel, frame_done}),
                 32'(rst_exp));
        @(negedge clk);
        check("rst_hold", 32'({mem_read_enable, mem_address, hsync, vsync, de, pixel, frame_done}),
              32'(rst_exp));
        rst = 1'b0;
        wait_cyc(1);
        check("rst_first_read", 32'({mem_read_enable, mem_address}), 32'({1'b1, 14'd0}));
        wait_cyc(2);
        check("rst_first_pixel", 32'({de, pixel}), 32'({1'b1, first_pix}));
        wait_cyc(40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/framebuffer_reader.md
# framebuffer_reader

Scan-out engine that reads the 256x256 8-bit framebuffer the processor writes into data memory and streams it as 640x480@60 VGA video. It sits on the read side of the data memory (14-bit word address, 32-bit data, synchronous one-cycle read), generates all sync and blanking timing, and pulses an end-of-frame event the processor side can poll. Pixels outside the 256x256 image window are driven black.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- clk  in  1  pixel clock (25 MHz nominal); single clock domain
- rst  in  1  asynchronous, active-high reset
- mem_read_enable  out  1  read strobe to data memory
- mem_address  out  14  word address to data memory
- mem_data  in  32  read data, valid the cycle after mem_read_enable
- hsync  out  1  horizontal sync, active low
- vsync  out  1  vertical sync, active low
- de  out  1  display enable (visible region)
- pixel  out  8  RRRGGGBB colour
- frame_done  out  1  one-cycle pulse at end of visible frame

## Operation
- Counters h (0..H_TOTAL-1, H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP=800) and v (0..V_TOTAL-1, 525). h increments every clock; at h=H_TOTAL-1 h wraps to 0 and v increments; at (H_TOTAL-1, V_TOTAL-1) both wrap to 0.
- Image window: h<256 and v<256. Word address = {v[7:0], h[7:2]} (v*64 + h/4).
- mem_read_enable=1 exactly on counter cycles with h[1:0]=0 inside the window; mem_address carries the address that cycle, else holds last value.
- Returned word latched into a 32-bit pixel register the next cycle. Byte order little-endian: h%4=0 -> bits [7:0], 1 -> [15:8], 2 -> [23:16], 3 -> [31:24].
- Inside window: pixel = selected byte. Visible but outside window: pixel = 8'h00. Blanking (de=0): pixel = 8'h00.
- hsync=0 for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC; vsync=0 for V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC.
- frame_done=1 for the single counter cycle (h=0, v=V_ACTIVE).
- No backpressure; memory is assumed always ready (one-cycle fixed latency).

## Timing
- Reset values: h=0, v=0, mem_read_enable=0, mem_address=0, hsync=1, vsync=1, de=0, pixel=0, frame_done=0.
- mem_read_enable/mem_address are registered: asserted 1 clock after counter reaches the word's first pixel... specifically outputs reflect counter value of previous cycle (latency 1).
- hsync, vsync, de, pixel, frame_done: all registered and aligned, lagging the counter by 2 clocks; mem_data sampled 1 clock after mem_read_enable high.
- First frame after reset release: first mem_read_enable at clock 1 (address 0), de=1 and pixel from word 0 byte 0 at clock 2.
- Frame period exactly 800*525 = 420000 clocks; frame_done period identical.
- Reset mid-frame: all outputs return to reset values asynchronously; pipeline contents discarded; scan restarts at (0,0) on the first clock after release.

## Configuration
- FB_BORDER_EN: when defined, pixels with (h,v) on the image window perimeter (h=0, h=255, v=0 or v=255) are forced to 8'hFF instead of memory data; memory reads unchanged. When undefined, perimeter pixels come from memory like all others.

## Test plan
- Reset: assert rst mid-line -> all outputs at reset values immediately; after release, mem_read_enable=1 with mem_address=0 at clock 1.
- Byte order: memory word 0 = 32'h44332211 -> pixel sequence 8'h11,22,33,44 on de clocks 0..3 of line 0.
- Addressing: line 5, h=8..11 -> mem_address=14'd322 (5*64+2) issued once, mem_read_enable low on h%4!=0 and for h>=256 or v>=256 (pixel=0, de=1 at h=300).
- Sync timing: hsync low exactly 96 clocks starting 656 clocks after de rises; vsync low exactly 1600 clocks (2 lines) starting line 490.
- Frame: frame_done pulses once per 420000 clocks, coincident with first cycle of line 480 (de=0).
- FB_BORDER_EN defined, memory all 8'h00 -> pixel=8'hFF at (0,0), (255,10), (10,255); pixel=0 at (1,1).
